// File: rtl/pipelined_sr_shifter_pkg.sv
// Shared definitions for the pipelined right barrel shifter.
//   DATA_W     - operand width (fixed at 32)
//   SHAMT_W    - shift amount width
//   NUM_STAGES - one pipeline stage per shift-amount bit
//   TAG_W_DEF  - default pass-through tag width
//   stage_t    - per-stage record at the default tag width; the top level
//                re-declares the same layout at its own TAG_W.
package shifter_pkg;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned SHAMT_W    = 5;
   localparam int unsigned NUM_STAGES = 5;
   localparam int unsigned TAG_W_DEF  = 5;

   typedef struct packed {
      logic                 valid;
      logic [DATA_W-1:0]    data;
      logic [SHAMT_W-1:0]   shamt;
      logic                 arith;
      logic [TAG_W_DEF-1:0] tag;
   } stage_t;

endpackage

// File: rtl/pipelined_sr_shifter_if.sv
// Handshake bundle for the shifter.
//   in_valid/in_ready     - input handshake
//   data_operandA         - value to shift
//   ctrl_shiftamt         - shift distance 0..31
//   ctrl_arith            - 1 = sign fill, 0 = zero fill
//   in_tag/out_tag        - opaque tag carried alongside the operation
//   out_valid/out_ready   - output handshake
//   data_result           - shifted value
// master = producer/consumer side, slave = shifter side.
interface pipelined_sr_shifter_if #(
   parameter int unsigned TAG_W = 5
);
   import shifter_pkg::*;

   logic               in_valid;
   logic               in_ready;
   logic [DATA_W-1:0]  data_operandA;
   logic [SHAMT_W-1:0] ctrl_shiftamt;
   logic               ctrl_arith;
   logic [TAG_W-1:0]   in_tag;
   logic               out_valid;
   logic               out_ready;
   logic [DATA_W-1:0]  data_result;
   logic [TAG_W-1:0]   out_tag;

   modport master (
      output in_valid, data_operandA, ctrl_shiftamt, ctrl_arith, in_tag, out_ready,
      input  in_ready, out_valid, data_result, out_tag
   );

   modport slave (
      input  in_valid, data_operandA, ctrl_shiftamt, ctrl_arith, in_tag, out_ready,
      output in_ready, out_valid, data_result, out_tag
   );

endinterface

// File: rtl/pipelined_sr_shifter_stage.sv
// One stage of the right barrel shifter: conditionally shifts the incoming
// record right by 2^STAGE_IDX and registers it.
//   clock, reset - clock and async active-low reset
//   flush        - clears the stage valid bit on the next edge
//   adv_i        - this stage may take a new value this cycle
//   prev_i       - predecessor record (or the input offer for stage 0)
//   stage_o      - registered record of this stage
module sr_shift_stage #(
   parameter int unsigned STAGE_IDX = 0,
   parameter type         stage_t   = shifter_pkg::stage_t
) (
   input  logic   clock,
   input  logic   reset,
   input  logic   flush,
   input  logic   adv_i,
   input  stage_t prev_i,
   output stage_t stage_o
);
   import shifter_pkg::*;

   localparam int unsigned Dist = 1 << STAGE_IDX;

   stage_t              stage_d, stage_q;
   logic                fill;
   logic [2*DATA_W-1:0] wide;
   logic [DATA_W-1:0]   shifted;

   // Bit 31 always carries the original sign, so every stage can derive the
   // fill from its own incoming value.
   always_comb begin
      fill    = prev_i.arith & prev_i.data[DATA_W-1];
      wide    = {{DATA_W{fill}}, prev_i.data};
      shifted = prev_i.shamt[STAGE_IDX] ? wide[Dist +: DATA_W] : prev_i.data;
   end

   // Empty predecessor leaves a bubble; payload is held so outputs stay quiet.
   always_comb begin
      stage_d = stage_q;
      if (flush) begin
         stage_d.valid = 1'b0;
      end else if (adv_i) begin
         if (prev_i.valid) begin
            stage_d      = prev_i;
            stage_d.data = shifted;
         end else begin
            stage_d.valid = 1'b0;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign stage_o = stage_q;

endmodule

// File: rtl/pipelined_sr_shifter.sv
// Five-stage pipelined SRL/SRA shifter with valid/ready handshakes and
// per-stage bubble collapse. Stage k resolves shift-amount bit k.
//   clock  - rising-edge clock
//   reset  - asynchronous active-low reset, clears all state
//   flush  - synchronous kill of in-flight and incoming operations
//   bus_io - handshake bundle (slave side)
//   busy   - any stage holds a valid operation
module pipelined_sr_shifter #(
   parameter int unsigned TAG_W  = 5,
   parameter int unsigned DATA_W = 32
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         flush,
   pipelined_sr_shifter_if.slave        bus_io,
   output logic                         busy
);
   import shifter_pkg::*;

   typedef struct packed {
      logic               valid;
      logic [DATA_W-1:0]  data;
      logic [SHAMT_W-1:0] shamt;
      logic               arith;
      logic [TAG_W-1:0]   tag;
   } stage_rec_t;

   // chain[0] is the input offer, chain[k+1] is the register of stage k.
   stage_rec_t            chain [NUM_STAGES+1];
   logic [NUM_STAGES-1:0] adv;
   logic [NUM_STAGES-1:0] vld;

   assign chain[0] = '{
      valid: bus_io.in_valid,
      data:  bus_io.data_operandA,
      shamt: bus_io.ctrl_shiftamt,
      arith: bus_io.ctrl_arith,
      tag:   bus_io.in_tag
   };

   for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
      sr_shift_stage #(
         .STAGE_IDX (k),
         .stage_t   (stage_rec_t)
      ) u_stage (
         .clock   (clock),
         .reset   (reset),
         .flush   (flush),
         .adv_i   (adv[k]),
         .prev_i  (chain[k]),
         .stage_o (chain[k+1])
      );

      assign vld[k] = chain[k+1].valid;

      // A stage may advance if downstream advances or it holds a bubble.
      if (k == NUM_STAGES - 1) begin : g_last
         assign adv[k] = bus_io.out_ready | ~vld[k];
      end else begin : g_mid
         assign adv[k] = adv[k+1] | ~vld[k];
      end
   end

   assign bus_io.in_ready    = adv[0];
   assign bus_io.out_valid   = vld[NUM_STAGES-1];
   assign bus_io.data_result = chain[NUM_STAGES].data;
   assign bus_io.out_tag     = chain[NUM_STAGES].tag;
   assign busy               = |vld;

   logic unused_tail;
   assign unused_tail = ^{chain[NUM_STAGES].shamt, chain[NUM_STAGES].arith};

endmodule

// File: tb/tb_pipelined_sr_shifter.sv
// Bench for pipelined_sr_shifter: table of hand-computed vectors, directed
// rate/backpressure/flush/reset sequences, and a random sweep checked by an
// in-order scoreboard.
module tb_pipelined_sr_shifter;

   localparam int unsigned TagW = 5;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic flush = 1'b0;
   logic busy;

   pipelined_sr_shifter_if #(.TAG_W(TagW)) sif ();

   pipelined_sr_shifter #(
      .TAG_W  (TagW),
      .DATA_W (32)
   ) dut (
      .clock  (clock),
      .reset  (reset),
      .flush  (flush),
      .bus_io (sif.slave),
      .busy   (busy)
   );

   always #5 clock = ~clock;

   int n_chk = 0;
   int n_err = 0;
   int n_in  = 0;
   int n_out = 0;

   typedef struct packed {
      logic [31:0]     d;
      logic [TagW-1:0] t;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   typedef struct {
      logic [31:0] a;
      logic [4:0]  sh;
      logic        ar;
      logic [31:0] exp;
   } vec_t;

   vec_t vec [16];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_sr(input logic [31:0] a, input logic [4:0] sh,
                                          input logic ar);
      logic [63:0] w;
      w = {{32{ar & a[31]}}, a} >> sh;
      return w[31:0];
   endfunction

   // Scoreboard: sampled on the falling edge, i.e. the values the next
   // rising edge will act on.
   always @(negedge clock) begin
      if (!reset) begin
         sb_q.delete();
      end else begin
         if (sif.out_valid && sif.out_ready) begin
            n_out++;
            chk("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
               mon_e = sb_q.pop_front();
               chk("sb_result", 64'({sif.out_tag, sif.data_result}), 64'({mon_e.t, mon_e.d}));
            end
         end
         if (flush) begin
            sb_q.delete();
         end else if (sif.in_valid && sif.in_ready) begin
            n_in++;
            sb_q.push_back('{d: ref_sr(sif.data_operandA, sif.ctrl_shiftamt, sif.ctrl_arith),
                             t: sif.in_tag});
         end
      end
   end

   task automatic drive(input logic [31:0] a, input logic [4:0] sh, input logic ar,
                        input logic [TagW-1:0] tg);
      sif.data_operandA = a;
      sif.ctrl_shiftamt = sh;
      sif.ctrl_arith    = ar;
      sif.in_tag        = tg;
      sif.in_valid      = 1'b1;
   endtask

   // Offer one op and return at posedge+1 after the edge that accepted it.
   task automatic send(input logic [31:0] a, input logic [4:0] sh, input logic ar,
                       input logic [TagW-1:0] tg);
      logic acc;
      int   n;
      drive(a, sh, ar, tg);
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 50) begin
         @(negedge clock);
         acc = sif.in_ready;
         @(posedge clock);
         #1;
         n++;
      end
      chk("send_accept", 64'(acc), 64'd1);
      sif.in_valid = 1'b0;
   endtask

   // Counts edges from the accepting edge (counted as 1) to out_valid.
   task automatic wait_out(output int edges);
      edges = 1;
      while (!sif.out_valid && edges < 20) begin
         @(posedge clock);
         #1;
         edges++;
      end
   endtask

   task automatic wait_idle(input int limit, output int n);
      n = 0;
      while (busy && n < limit) begin
         @(posedge clock);
         #1;
         n++;
      end
   endtask

   initial begin
      int lat;
      int n;
      int out0;
      int in0;
      int cyc;

      vec[0]  = '{32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF};
      vec[1]  = '{32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001};
      vec[2]  = '{32'hF0F0_F0F0, 5'd4,  1'b0, 32'h0F0F_0F0F};
      vec[3]  = '{32'hF0F0_F0F0, 5'd4,  1'b1, 32'hFF0F_0F0F};
      vec[4]  = '{32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678};
      vec[5]  = '{32'h7FFF_FFFF, 5'd16, 1'b1, 32'h0000_7FFF};
      vec[6]  = '{32'h8000_0000, 5'd1,  1'b1, 32'hC000_0000};
      vec[7]  = '{32'hDEAD_BEEF, 5'd8,  1'b0, 32'h00DE_ADBE};
      vec[8]  = '{32'hDEAD_BEEF, 5'd8,  1'b1, 32'hFFDE_ADBE};
      vec[9]  = '{32'hAAAA_AAAA, 5'd31, 1'b1, 32'hFFFF_FFFF};
      vec[10] = '{32'h5555_5555, 5'd3,  1'b1, 32'h0AAA_AAAA};
      vec[11] = '{32'h8000_0001, 5'd0,  1'b1, 32'h8000_0001};
      vec[12] = '{32'h8765_4321, 5'd12, 1'b1, 32'hFFF8_7654};
      vec[13] = '{32'h8765_4321, 5'd12, 1'b0, 32'h0008_7654};
      vec[14] = '{32'h8000_0000, 5'd21, 1'b1, 32'hFFFF_FC00};
      vec[15] = '{32'h8000_0000, 5'd21, 1'b0, 32'h0000_0400};

      sif.in_valid      = 1'b0;
      sif.data_operandA = '0;
      sif.ctrl_shiftamt = '0;
      sif.ctrl_arith    = 1'b0;
      sif.in_tag        = '0;
      sif.out_ready     = 1'b1;

      // Reset state
      #1;
      chk("rst_out_valid", 64'(sif.out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_data", 64'(sif.data_result), 64'd0);
      chk("rst_tag", 64'(sif.out_tag), 64'd0);
      repeat (3) @(posedge clock);
      @(negedge clock);
      #2 reset = 1'b1;
      @(posedge clock);
      #1;
      chk("rst_in_ready", 64'(sif.in_ready), 64'd1);
      chk("rst_out_valid_post", 64'(sif.out_valid), 64'd0);

      // Table: one op at a time, latency + value + tag
      for (int i = 0; i < 16; i++) begin
         send(vec[i].a, vec[i].sh, vec[i].ar, TagW'(i));
         wait_out(lat);
         chk("tbl_latency", 64'(lat), 64'd5);
         chk("tbl_data", 64'(sif.data_result), 64'(vec[i].exp));
         chk("tbl_tag", 64'(sif.out_tag), 64'(i));
      end
      @(posedge clock);
      #1;

      // Full rate: four back-to-back ops, one result per cycle
      for (int i = 0; i < 4; i++) begin
         send(vec[2+i].a, vec[2+i].sh, vec[2+i].ar, TagW'(i + 1));
      end
      wait_out(lat);
      chk("rate_first", 64'(lat), 64'd2);
      for (int i = 0; i < 4; i++) begin
         chk("rate_valid", 64'(sif.out_valid), 64'd1);
         chk("rate_tag", 64'(sif.out_tag), 64'(i + 1));
         chk("rate_data", 64'(sif.data_result), 64'(vec[2+i].exp));
         @(posedge clock);
         #1;
      end
      chk("rate_idle", 64'(busy), 64'd0);

      // Backpressure: 5 fill the pipe, 6th is refused, then drain all 7
      out0 = n_out;
      sif.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         send(vec[6+i].a, vec[6+i].sh, vec[6+i].ar, TagW'(8 + i));
      end
      drive(vec[11].a, vec[11].sh, vec[11].ar, TagW'(13));
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("bp_in_ready", 64'(sif.in_ready), 64'd0);
         chk("bp_busy", 64'(busy), 64'd1);
         chk("bp_out_valid", 64'(sif.out_valid), 64'd1);
         chk("bp_data_hold", 64'(sif.data_result), 64'(vec[6].exp));
         chk("bp_tag_hold", 64'(sif.out_tag), 64'd8);
         @(posedge clock);
         #1;
      end
      sif.out_ready = 1'b1;
      send(vec[11].a, vec[11].sh, vec[11].ar, TagW'(13));
      send(vec[12].a, vec[12].sh, vec[12].ar, TagW'(14));
      wait_idle(40, n);
      chk("bp_drain_idle", 64'(busy), 64'd0);
      chk("bp_delivered", 64'(n_out - out0), 64'd7);
      chk("bp_sb_empty", 64'(sb_q.size()), 64'd0);

      // Flush with 3 in flight and a new op offered in the same cycle
      for (int i = 0; i < 3; i++) begin
         send(vec[i].a, vec[i].sh, vec[i].ar, TagW'(20 + i));
      end
      drive(vec[3].a, vec[3].sh, vec[3].ar, TagW'(30));
      flush = 1'b1;
      @(posedge clock);
      #1;
      flush        = 1'b0;
      sif.in_valid = 1'b0;
      chk("flush_out_valid", 64'(sif.out_valid), 64'd0);
      chk("flush_busy", 64'(busy), 64'd0);
      out0 = n_out;
      repeat (10) @(posedge clock);
      #1;
      chk("flush_no_emerge", 64'(n_out - out0), 64'd0);
      chk("flush_still_idle", 64'(busy), 64'd0);

      // Asynchronous reset mid-cycle with 4 in flight
      for (int i = 0; i < 4; i++) begin
         send(vec[8+i].a, vec[8+i].sh, vec[8+i].ar, TagW'(24 + i));
      end
      #3 reset = 1'b0;
      #1;
      chk("mrst_out_valid", 64'(sif.out_valid), 64'd0);
      chk("mrst_data", 64'(sif.data_result), 64'd0);
      chk("mrst_busy", 64'(busy), 64'd0);
      chk("mrst_tag", 64'(sif.out_tag), 64'd0);
      @(negedge clock);
      #2 reset = 1'b1;
      @(posedge clock);
      #1;
      chk("mrst_in_ready", 64'(sif.in_ready), 64'd1);
      chk("mrst_no_spurious", 64'(sif.out_valid), 64'd0);
      send(vec[14].a, vec[14].sh, vec[14].ar, TagW'(31));
      wait_out(lat);
      chk("mrst_latency", 64'(lat), 64'd5);
      chk("mrst_data_new", 64'(sif.data_result), 64'(vec[14].exp));
      chk("mrst_tag_new", 64'(sif.out_tag), 64'd31);
      @(posedge clock);
      #1;

      // Random sweep against the scoreboard
      in0 = n_in;
      cyc = 0;
      while ((n_in - in0) < 10000 && cyc < 60000) begin
         sif.out_ready     = ($urandom_range(3) != 0);
         sif.in_valid      = ($urandom_range(7) != 0);
         sif.data_operandA = $urandom();
         sif.ctrl_shiftamt = 5'($urandom());
         sif.ctrl_arith    = 1'($urandom());
         sif.in_tag        = TagW'(n_in);
         @(posedge clock);
         #1;
         cyc++;
      end
      sif.in_valid  = 1'b0;
      sif.out_ready = 1'b1;
      chk("rnd_accepted", 64'((n_in - in0) >= 10000), 64'd1);
      wait_idle(40, n);
      chk("rnd_drain_idle", 64'(busy), 64'd0);
      chk("rnd_sb_empty", 64'(sb_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
